// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for the regfile's single write port: round-robin grant among
// NUM_REQ sources, a registered write stage, and a pending-write scoreboard for RAW checks.
module rf_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = 32,
    parameter int AW      = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*AW-1:0]   req_rd,
    input  logic [NUM_REQ*XLEN-1:0] req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    rf_we,
    output logic [AW-1:0]           rf_rd,
    output logic [XLEN-1:0]         rf_rd_data,
    input  logic                    sb_set,
    input  logic [AW-1:0]           sb_set_rd,
    input  logic                    sb_flush,
    input  logic [AW-1:0]           chk_rs1,
    input  logic [AW-1:0]           chk_rs2,
    output logic                    rs1_busy,
    output logic                    rs2_busy
);

    localparam int PW   = $clog2(NUM_REQ);
    localparam int NREG = 1 << AW;

    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   grant_idx;
    logic [PW-1:0]   idx;
    logic            grant_valid;
    logic [AW-1:0]   gnt_rd;
    logic [XLEN-1:0] gnt_data;
    logic            wb_en;
    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_nxt;

    // Circular search for the first valid requester starting at rr_ptr.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = PW'((int'(rr_ptr) + k) % NUM_REQ);
            if (!grant_valid && req_valid[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
            end
        end
    end

    always_comb begin
        gnt_rd   = '0;
        gnt_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == PW'(i)) begin
                gnt_rd   = req_rd[i*AW +: AW];
                gnt_data = req_data[i*XLEN +: XLEN];
            end
        end
    end

    assign req_ready = grant_valid ? (NUM_REQ'(1) << grant_idx) : '0;

    // Writes to x0 are consumed but never reach the regfile or the scoreboard.
    assign wb_en = grant_valid && (gnt_rd != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (grant_valid) begin
            rr_ptr <= (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we      <= 1'b0;
            rf_rd      <= '0;
            rf_rd_data <= '0;
        end else if (wb_en) begin
            rf_we      <= 1'b1;
            rf_rd      <= gnt_rd;
            rf_rd_data <= gnt_data;
        end else begin
            rf_we      <= 1'b0;
        end
    end

    // Set is applied after clear so a newly issued producer keeps its register busy.
    always_comb begin
        pending_nxt = pending;
        if (wb_en) begin
            pending_nxt[gnt_rd] = 1'b0;
        end
        if (sb_set && (sb_set_rd != '0)) begin
            pending_nxt[sb_set_rd] = 1'b1;
        end
        if (sb_flush) begin
            pending_nxt = '0;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    assign rs1_busy = (chk_rs1 != '0) && pending[chk_rs1];
    assign rs2_busy = (chk_rs2 != '0) && pending[chk_rs2];

endmodule
